// File: rtl/cp0_exc_if.sv
// MEM-stage exception bundle, mtc0/mfc0/eret controls and exception redirect outputs of cp0_exc_unit.
interface cp0_exc_if;
  logic [31:0] MEMPC;
  logic        MEMBD;
  logic [31:0] MEMErrorCode;
  logic [5:0]  HWInt;
  logic        CP0WE;
  logic [4:0]  CP0Addr;
  logic [31:0] CP0WD;
  logic        EretEn;
  logic [31:0] CP0RD;
  logic [31:0] EPCOut;
  logic        IntReq;
  logic [31:0] HandlerPC;

  modport master (
    output MEMPC, MEMBD, MEMErrorCode, HWInt, CP0WE, CP0Addr, CP0WD, EretEn,
    input  CP0RD, EPCOut, IntReq, HandlerPC
  );

  modport slave (
    input  MEMPC, MEMBD, MEMErrorCode, HWInt, CP0WE, CP0Addr, CP0WD, EretEn,
    output CP0RD, EPCOut, IntReq, HandlerPC
  );
endinterface

// File: rtl/cp0_exc_unit.sv
// CP0 (SR/Cause/EPC/PRId) and exception entry at MEM; IntReq is combinational, state updates at the edge.
// Define CP0_TIMER_EN to add Count/Compare and a timer interrupt on IP[7].
module cp0_exc_unit #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID_VALUE   = 32'h0000_2024
) (
  input logic        clk,
  input logic        reset,
  cp0_exc_if.slave   bus
);

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:2] epc;
  logic        timer_irq;

  logic [5:0]  hw_eff;
  logic        valid;
  logic        int_pend;
  logic        exc_pend;
  logic        int_req;
  logic [4:0]  taken_code;
  logic        cp0_wr;
  logic        unused_errcode;

  assign unused_errcode = ^bus.MEMErrorCode[31:5];

  assign hw_eff     = bus.HWInt | {timer_irq, 5'b0};
  assign valid      = (bus.MEMPC != 32'hFFFF_FFFF);
  assign int_pend   = (|(hw_eff & sr_im)) & sr_ie & ~sr_exl;
  assign exc_pend   = (bus.MEMErrorCode[4:0] != 5'd0) & ~sr_exl;
  assign int_req    = valid & (int_pend | exc_pend);
  assign taken_code = int_pend ? 5'd0 : bus.MEMErrorCode[4:0];
  // An instruction taking an exception must not also commit its mtc0/eret.
  assign cp0_wr     = bus.CP0WE & ~int_req;

  assign bus.IntReq    = int_req;
  assign bus.HandlerPC = HANDLER_ADDR;
  assign bus.EPCOut    = (bus.CP0WE && bus.CP0Addr == 5'd14) ? {bus.CP0WD[31:2], 2'b00}
                                                              : {epc, 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      cause_ip <= hw_eff;
      if (int_req) begin
        sr_exl    <= 1'b1;
        cause_exc <= taken_code;
        cause_bd  <= bus.MEMBD;
        // Delay-slot faults restart at the branch, one word back.
        epc       <= bus.MEMBD ? (bus.MEMPC[31:2] - 30'd1) : bus.MEMPC[31:2];
      end else begin
        if (cp0_wr && bus.CP0Addr == 5'd12) begin
          sr_im <= bus.CP0WD[15:10];
          sr_ie <= bus.CP0WD[0];
        end
        if (bus.EretEn)
          sr_exl <= 1'b0;
        else if (cp0_wr && bus.CP0Addr == 5'd12)
          sr_exl <= bus.CP0WD[1];
        if (cp0_wr && bus.CP0Addr == 5'd14)
          epc <= bus.CP0WD[31:2];
      end
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count;
  logic [31:0] compare;
  logic [31:0] count_nxt;
  logic [31:0] compare_nxt;
  logic        compare_wr;

  assign compare_wr  = cp0_wr && bus.CP0Addr == 5'd11;
  assign count_nxt   = (cp0_wr && bus.CP0Addr == 5'd9) ? bus.CP0WD : count + 32'd1;
  assign compare_nxt = compare_wr ? bus.CP0WD : compare;

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      compare   <= '0;
      timer_irq <= 1'b0;
    end else begin
      count     <= count_nxt;
      compare   <= compare_nxt;
      timer_irq <= (count_nxt == compare_nxt) | (timer_irq & ~compare_wr);
    end
  end
`else
  assign timer_irq = 1'b0;
`endif

  always_comb begin
    bus.CP0RD = 32'd0;
    case (bus.CP0Addr)
      5'd12: bus.CP0RD = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
      5'd13: bus.CP0RD = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'b00};
      5'd14: bus.CP0RD = {epc, 2'b00};
      5'd15: bus.CP0RD = PRID_VALUE;
`ifdef CP0_TIMER_EN
      5'd9:  bus.CP0RD = count;
      5'd11: bus.CP0RD = compare;
`endif
      default: bus.CP0RD = 32'd0;
    endcase
  end

endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
- Coprocessor-0 and exception-entry unit at the MEM stage. It consumes the exception bundle carried by the EX/MEM pipeline register: MEMPC, MEMBD and MEMErrorCode. MEMErrorCode holds an ExcCode; overflow arrives already encoded as 12.
- It combines that bundle with external hardware interrupts. It decides whether the exception is taken, and if so it raises the pipeline-wide flush/redirect request.
- It holds the SR, Cause, EPC and PRId registers, services mtc0/mfc0, and handles eret.

Parameters:
- HANDLER_ADDR, 32'h0000_4180, PC of the exception handler.
- PRID_VALUE, 32'h0000_2024, read-only PRId contents.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-high.
- MEMPC, input, 32, PC of the instruction in MEM. 32'hFFFF_FFFF marks a bubble.
- MEMBD, input, 1, MEM instruction is in a delay slot.
- MEMErrorCode, input, 32, ExcCode; 0 means no exception. Only bits [4:0] are significant.
- HWInt, input, 6, external interrupt lines IP[7:2].
- CP0WE, input, 1, mtc0 write enable.
- CP0Addr, input, 5, CP0 register number for mtc0/mfc0.
- CP0WD, input, 32, mtc0 write data.
- EretEn, input, 1, eret is in MEM.
- CP0RD, output, 32, mfc0 read data (combinational).
- EPCOut, output, 32, eret target, with forwarding.
- IntReq, output, 1, take an exception this cycle; flushes all pipeline registers.
- HandlerPC, output, 32, equals HANDLER_ADDR.

Behaviour:
- Register layout:
  - SR (reg 12): IM=[15:10], EXL=[1], IE=[0]; all other bits read 0.
  - Cause (reg 13): BD=[31], IP=[15:10], ExcCode=[6:2]; all other bits read 0.
  - EPC (reg 14): 32 bits, bits [1:0] always 0.
  - PRId (reg 15): PRID_VALUE, read-only.
  - Reads of any other address return 0.
- Reset: SR=0, Cause=0, EPC=0. The outputs follow from these: IntReq=0, CP0RD=0 for regs 12–14, EPCOut=0.
- Cause.IP is sampled from HWInt every cycle, including while EXL=1. It is not writable by mtc0.
- Conditions, all combinational:
  - Valid = (MEMPC != 32'hFFFF_FFFF).
  - IntPend = |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
  - ExcPend = (MEMErrorCode[4:0] != 0) & ~SR.EXL.
  - IntReq = Valid & (IntPend | ExcPend).
- An interrupt arriving while MEM holds a bubble is deferred. IntReq stays 0 until a valid instruction reaches MEM, provided HWInt is still asserted then.
- Priority: interrupt over exception. Taken ExcCode = IntPend ? 0 : MEMErrorCode[4:0].
- On the clock edge with IntReq=1:
  - SR.EXL <= 1.
  - Cause.ExcCode <= taken code.
  - Cause.BD <= MEMBD.
  - EPC <= (MEMBD ? MEMPC-4 : MEMPC) & ~3.
  - A simultaneous mtc0 and a simultaneous eret are both ignored in this cycle.
- mtc0 (CP0WE=1, IntReq=0):
  - Writes SR.IM/EXL/IE or EPC at the edge.
  - Writes to Cause and PRId are ignored.
- eret (EretEn=1, IntReq=0): SR.EXL <= 0 at the edge.
- mtc0 and eret in the same cycle:
  - An mtc0 to SR applies first, then eret clears EXL.
  - An mtc0 to EPC updates EPC.
- EPCOut = (CP0WE & CP0Addr==14) ? CP0WD & ~3 : EPC. This forwarding covers an mtc0-then-eret sequence.
- CP0RD reads the current register values, not same-cycle write data.
- Latency: detection and IntReq in the same cycle; state is visible from the next cycle.
- Reset has priority over everything in progress. A reset concurrent with IntReq leaves all registers at 0.

Optional Feature:
- CP0_TIMER_EN compiled in:
  - Adds Count (reg 9) and Compare (reg 11).
  - Count increments by 1 every cycle, wrapping at 2^32, and is writable by mtc0; a written value takes effect at the edge, replacing that cycle's increment.
  - Writing Compare clears TimerIrq.
  - TimerIrq is set when Count==Compare after the edge, and holds until Compare is written.
  - TimerIrq is ORed into IP[7] (HWInt[5]) before both IntPend and Cause.IP.
  - Both registers reset to 0.
- CP0_TIMER_EN absent: regs 9 and 11 read 0, and no internal interrupt source exists.

Test Plan:
- Overflow exception: set SR=32'h0000_FC01. Apply MEMErrorCode=12, MEMPC=32'h3010, MEMBD=0. Required: IntReq=1 that cycle. Next cycle: EPC=32'h3010, Cause[6:2]=12, SR.EXL=1, IntReq=0.
- Delay-slot interrupt: SR=32'h0000_0401, HWInt=6'b000001, MEMPC=32'h3024, MEMBD=1. Required: IntReq=1. Next cycle: EPC=32'h3020, Cause=32'h8000_0400, ExcCode=0.
- Bubble deferral: HWInt asserted with interrupts enabled while MEMPC=32'hFFFF_FFFF for 2 cycles. Required: IntReq=0 for both cycles, then 1 when MEMPC=32'h3040.
- Masking: with EXL=1, MEMErrorCode=4. Required: IntReq=0. After eret, next cycle EXL=0.
- Same-cycle mtc0 EPC plus eret: CP0WE=1, CP0Addr=14, CP0WD=32'h3083, EretEn=1. Required: EPCOut=32'h3080 in the same cycle.
- CP0_TIMER_EN: Compare=5, Count=0, SR=32'h0000_8001. Required: IntReq=1 on the cycle Count reads 5 with MEMPC valid.
